// File: rtl/reg_bank_loader.sv
// reg_bank_loader: parses two-byte (header, data) write frames from a valid/ready byte stream into register-bank load strobes
// Ports: CLK clock; RST async active-low reset; S_DATA/S_VALID/S_READY byte stream input;
//        DIN bank data bus; RG1/RG2/RG3 one-hot load strobes; ERR one-cycle frame error pulse;
//        WR_CNT wrapping count of successful writes.
// Header: bit7 start flag, bits[1:0] target register (00 invalid), bit6 data parity when
//         REG_BANK_LOADER_PARITY_EN is defined (ignored otherwise).
module reg_bank_loader #(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] S_DATA,
  input  logic       S_VALID,
  output logic       S_READY,
  output logic [7:0] DIN,
  output logic       RG1,
  output logic       RG2,
  output logic       RG3,
  output logic       ERR,
  output logic [7:0] WR_CNT
);
  localparam logic [1:0] IDLE = 2'd0, WAIT_DATA = 2'd1, DROP = 2'd2, STROBE = 2'd3;
  logic [1:0] state;
  logic [1:0] sel;
  logic [TO_W-1:0] cnt;
  logic acc;
  logic bad;
  logic unused;
  assign acc = S_VALID && S_READY;
  assign unused = ^S_DATA[6:2];
`ifdef REG_BANK_LOADER_PARITY_EN
  logic par;
  assign bad = par != ^S_DATA;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) par <= 1'b0;
    else if (state == IDLE && acc) par <= S_DATA[6];
`else
  assign bad = 1'b0;
`endif
  // S_READY is registered: it reflects the state being entered, so it is low only for STROBE
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      sel     <= 2'd0;
      cnt     <= '0;
      S_READY <= 1'b0;
      DIN     <= 8'h00;
      RG1     <= 1'b0;
      RG2     <= 1'b0;
      RG3     <= 1'b0;
      ERR     <= 1'b0;
      WR_CNT  <= 8'h00;
    end else begin
      S_READY <= 1'b1;
      RG1     <= 1'b0;
      RG2     <= 1'b0;
      RG3     <= 1'b0;
      ERR     <= 1'b0;
      case (state)
        IDLE: if (acc) begin
          if (!S_DATA[7]) ERR <= 1'b1;
          else if (S_DATA[1:0] == 2'd0) begin
            ERR   <= 1'b1;
            state <= DROP;
          end else begin
            sel   <= S_DATA[1:0];
            cnt   <= '0;
            state <= WAIT_DATA;
          end
        end
        WAIT_DATA: if (acc) begin
          // an accept on the final timeout cycle still completes the write
          DIN     <= S_DATA;
          state   <= STROBE;
          S_READY <= 1'b0;
          if (bad) ERR <= 1'b1;
          else begin
            RG1    <= sel == 2'd1;
            RG2    <= sel == 2'd2;
            RG3    <= sel == 2'd3;
            WR_CNT <= WR_CNT + 8'd1;
          end
        end else if (cnt == TO_W'(TIMEOUT - 1)) begin
          ERR   <= 1'b1;
          state <= IDLE;
        end else cnt <= cnt + 1'b1;
        DROP: if (acc) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_bank_loader.sv
// tb_reg_bank_loader: randomized and directed frame stimulus checked against a frame-level event model
module tb_reg_bank_loader;
  localparam int TIMEOUT = 64;
  localparam int EV_ERR = 'h1000;
`ifdef REG_BANK_LOADER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] S_DATA = 8'h00;
  logic       S_VALID = 1'b0;
  logic       S_READY;
  logic [7:0] DIN;
  logic       RG1, RG2, RG3, ERR;
  logic [7:0] WR_CNT;
  int n_checks = 0;
  int n_fail = 0;
  int exp_q[$];
  int obs_q[$];
  int m_st = 0;
  logic [7:0] m_hdr = 8'h00;
  logic [7:0] m_din = 8'h00;
  logic [7:0] m_cnt = 8'h00;

  reg_bank_loader #(.TIMEOUT(TIMEOUT), .TO_W(7)) dut (
    .CLK(CLK), .RST(RST), .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
    .DIN(DIN), .RG1(RG1), .RG2(RG2), .RG3(RG3), .ERR(ERR), .WR_CNT(WR_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // every cycle with a strobe or error becomes one observed event
  always @(negedge CLK) if (RST && (RG1 || RG2 || RG3 || ERR)) begin
    check("exclusive", 32'($onehot({RG1, RG2, RG3, ERR})), 1);
    if (RG1 || RG2 || RG3) begin
      check("ready_in_strobe", 32'(S_READY), 0);
      obs_q.push_back((RG1 ? 1 : RG2 ? 2 : 3) * 256 + int'(DIN));
    end
    if (ERR) obs_q.push_back(EV_ERR);
  end

  // present b after gap idle cycles and hold it until accepted; returns at the negedge after transfer
  task automatic send(input logic [7:0] b, input int gap);
    int w = 0;
    S_VALID = 1'b0;
    repeat (gap) @(negedge CLK);
    S_DATA = b;
    S_VALID = 1'b1;
    while (!S_READY && w < 8) begin
      @(negedge CLK);
      w++;
    end
    check("ready_wait", 32'(S_READY), 1);
    @(negedge CLK);
    S_VALID = 1'b0;
  endtask

  // frame-level model: a data byte arriving TIMEOUT or more idle cycles after its header is too late
  task automatic feed(input logic [7:0] b, input int gap);
    if (m_st == 1 && gap >= TIMEOUT) begin
      exp_q.push_back(EV_ERR);
      m_st = 0;
    end
    if (m_st == 0) begin
      if (!b[7]) exp_q.push_back(EV_ERR);
      else if (b[1:0] == 2'b00) begin
        exp_q.push_back(EV_ERR);
        m_st = 2;
      end else begin
        m_hdr = b;
        m_st = 1;
      end
    end else if (m_st == 1) begin
      m_din = b;
      if (PAR && (m_hdr[6] != ^b)) exp_q.push_back(EV_ERR);
      else begin
        exp_q.push_back(int'(m_hdr[1:0]) * 256 + int'(b));
        m_cnt = m_cnt + 8'd1;
      end
      m_st = 0;
    end else m_st = 0;
    send(b, gap);
  endtask

  task automatic flush(input string tag);
    if (m_st == 2) feed(8'h00, 0);
    if (m_st == 1) begin
      exp_q.push_back(EV_ERR);
      m_st = 0;
      repeat (TIMEOUT) @(negedge CLK);
    end
    repeat (3) @(negedge CLK);
    check({tag, "_ev_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) check({tag, "_event"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
    check({tag, "_din"}, DIN, m_din);
    check({tag, "_wr_cnt"}, WR_CNT, m_cnt);
    check({tag, "_ready"}, S_READY, 1);
  endtask

  initial begin
    #1;
    check("rst_din", DIN, 0);
    check("rst_rg", {RG1, RG2, RG3}, 0);
    check("rst_err", ERR, 0);
    check("rst_wr_cnt", WR_CNT, 0);
    check("rst_ready", S_READY, 0);
    repeat (2) @(negedge CLK);
    check("rst_ready_held", S_READY, 0);
    RST = 1'b1;
    @(negedge CLK);
    check("ready_after_rst", S_READY, 1);
    feed(8'h81, 0); feed(8'hA5, 0);
    flush("frame_rg1");
    feed(8'h82, 0); feed(8'h3C, 0); feed(8'h83, 0); feed(8'h0F, 0);
    flush("back_to_back");
    feed(8'h80, 0); feed(8'h55, 0); feed(8'h81, 0); feed(8'h11, 0);
    flush("drop");
    feed(8'h81, 0); feed(8'h02, TIMEOUT);
    flush("timeout");
    feed(8'h83, 0); feed(8'h5A, TIMEOUT - 1);
    flush("timeout_edge");
    feed(8'hC1, 0); feed(8'h01, 0); feed(8'h81, 0); feed(8'h01, 0);
    flush("parity");
    for (int i = 0; i < 256; i++) begin
      feed(8'h81 | 8'($urandom_range(0, 2)), 0);
      feed(8'($urandom) & 8'hBC, 0);
    end
    flush("wrap");
    for (int i = 0; i < 200; i++) begin
      logic [7:0] b;
      int r;
      int gap;
      b = 8'($urandom);
      if ($urandom_range(0, 3) != 0) b[7] = 1'b1;
      r = $urandom_range(0, 19);
      gap = r < 15 ? r % 3 : r == 15 ? TIMEOUT - 1 : r == 16 ? TIMEOUT : r == 17 ? TIMEOUT + 3 : 0;
      feed(b, gap);
    end
    flush("random");
    feed(8'h81, 0);
    RST = 1'b0;
    m_st = 0;
    m_din = 8'h00;
    m_cnt = 8'h00;
    #1;
    check("midrst_din", DIN, 0);
    check("midrst_rg", {RG1, RG2, RG3, ERR}, 0);
    check("midrst_wr_cnt", WR_CNT, 0);
    check("midrst_ready", S_READY, 0);
    repeat (3) @(negedge CLK);
    check("midrst_ready_held", S_READY, 0);
    RST = 1'b1;
    @(negedge CLK);
    check("midrst_release", S_READY, 1);
    feed(8'h82, 0); feed(8'h77, 0);
    flush("after_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
